// File: rtl/mwc_pkg.sv
// Shared types and constants for the memory write checker.
// States, fail codes and the expected-write entry layout.
package mwc_pkg;

    localparam int unsigned MWC_ADDR_W = 32;
    localparam int unsigned MWC_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PASS = 2'd2,
        FAIL = 2'd3
    } mwc_state_t;

    localparam logic [1:0] FC_NONE     = 2'd0;
    localparam logic [1:0] FC_MISMATCH = 2'd1;
    localparam logic [1:0] FC_TIMEOUT  = 2'd2;

    typedef struct packed {
        logic [MWC_ADDR_W-1:0] addr;
        logic [MWC_DATA_W-1:0] data;
    } exp_entry_t;

    // Index width for an n-entry table, never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mwc_exp_table.sv
// Expected-write register file: one write port, plus either an in-order read port
// or (MWC_UNORDERED_EN) an all-entries compare vector against the current bus write.
module mwc_exp_table
    import mwc_pkg::*;
#(
    parameter int unsigned NUM_EXP = 4,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned IDX_W   = idx_width(NUM_EXP)
) (
    input  logic               clk,
    input  logic               i_we,
    input  logic [IDX_W-1:0]   i_idx,
    input  logic [ADDR_W-1:0]  i_addr,
    input  logic [DATA_W-1:0]  i_data,
`ifdef MWC_UNORDERED_EN
    input  logic [ADDR_W-1:0]  i_cmp_addr,
    input  logic [DATA_W-1:0]  i_cmp_data,
    output logic [NUM_EXP-1:0] o_hit_vec
`else
    input  logic [IDX_W-1:0]   i_rd_idx,
    output logic [ADDR_W-1:0]  o_rd_addr,
    output logic [DATA_W-1:0]  o_rd_data
`endif
);

    logic [ADDR_W-1:0] r_addr [NUM_EXP];
    logic [DATA_W-1:0] r_data [NUM_EXP];

    // Contents are deliberately not reset so a loaded table survives a reset.
    always_ff @(posedge clk) begin
        if (i_we && (32'(i_idx) < NUM_EXP)) begin
            r_addr[i_idx] <= i_addr;
            r_data[i_idx] <= i_data;
        end
    end

`ifdef MWC_UNORDERED_EN
    always_comb begin
        o_hit_vec = '0;
        for (int unsigned i = 0; i < NUM_EXP; i++) begin
            o_hit_vec[i] = (r_addr[i] == i_cmp_addr) && (r_data[i] == i_cmp_data);
        end
    end
`else
    always_comb begin
        o_rd_addr = '0;
        o_rd_data = '0;
        if (32'(i_rd_idx) < NUM_EXP) begin
            o_rd_addr = r_addr[i_rd_idx];
            o_rd_data = r_data[i_rd_idx];
        end
    end
`endif

endmodule

// File: rtl/mem_write_checker.sv
// Self-check monitor on the CPU data-memory write bus against a table of expected writes.
// Define MWC_UNORDERED_EN to accept the expected writes in any order.
module mem_write_checker
    import mwc_pkg::*;
#(
    parameter int unsigned      ADDR_W      = 32,
    parameter int unsigned      DATA_W      = 32,
    parameter int unsigned      NUM_EXP     = 4,
    parameter int unsigned      TIMEOUT_CYC = 1000,
    parameter logic [ADDR_W-1:0] IGNORE_ADDR = ADDR_W'(96),
    localparam int unsigned     IDX_W       = idx_width(NUM_EXP),
    localparam int unsigned     CNT_W       = $clog2(NUM_EXP + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              exp_we,
    input  logic [IDX_W-1:0]  exp_idx,
    input  logic [ADDR_W-1:0] exp_addr,
    input  logic [DATA_W-1:0] exp_data,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] data_adr,
    input  logic [DATA_W-1:0] write_data,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [1:0]        fail_code,
    output logic [CNT_W-1:0]  match_cnt,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_data,
    output logic [31:0]       cycle_cnt
);

    mwc_state_t        r_state;
    logic              r_busy;
    logic              r_done;
    logic              r_pass;
    logic [1:0]        r_fail_code;
    logic [CNT_W-1:0]  r_match_cnt;
    logic [ADDR_W-1:0] r_fail_addr;
    logic [DATA_W-1:0] r_fail_data;
    logic [31:0]       r_cycle_cnt;

    logic              w_tbl_we;
    logic              w_check;
    logic              w_hit;
    logic              w_all;
    logic              w_timeout;
    logic [CNT_W-1:0]  w_cnt_nxt;

    assign w_tbl_we  = exp_we && (r_state == IDLE);
    assign w_check   = (r_state == RUN) && mem_write && (data_adr != IGNORE_ADDR);
    assign w_timeout = (r_cycle_cnt == 32'(TIMEOUT_CYC - 1));

`ifdef MWC_UNORDERED_EN
    logic [NUM_EXP-1:0] r_mask;
    logic [NUM_EXP-1:0] w_hit_vec;
    logic [NUM_EXP-1:0] w_avail;
    logic [NUM_EXP-1:0] w_pick;
    logic [NUM_EXP-1:0] w_mask_nxt;

    mwc_exp_table #(
        .NUM_EXP (NUM_EXP),
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .IDX_W   (IDX_W)
    ) u_table (
        .clk        (clk),
        .i_we       (w_tbl_we),
        .i_idx      (exp_idx),
        .i_addr     (exp_addr),
        .i_data     (exp_data),
        .i_cmp_addr (data_adr),
        .i_cmp_data (write_data),
        .o_hit_vec  (w_hit_vec)
    );

    // Two's-complement trick isolates the lowest unmatched hit.
    assign w_avail    = w_hit_vec & ~r_mask;
    assign w_pick     = w_avail & (~w_avail + NUM_EXP'(1));
    assign w_mask_nxt = r_mask | w_pick;
    assign w_hit      = |w_avail;
    assign w_all      = &w_mask_nxt;
    assign w_cnt_nxt  = CNT_W'($countones(w_mask_nxt));
`else
    logic [ADDR_W-1:0] w_rd_addr;
    logic [DATA_W-1:0] w_rd_data;

    mwc_exp_table #(
        .NUM_EXP (NUM_EXP),
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .IDX_W   (IDX_W)
    ) u_table (
        .clk       (clk),
        .i_we      (w_tbl_we),
        .i_idx     (exp_idx),
        .i_addr    (exp_addr),
        .i_data    (exp_data),
        .i_rd_idx  (IDX_W'(r_match_cnt)),
        .o_rd_addr (w_rd_addr),
        .o_rd_data (w_rd_data)
    );

    assign w_hit     = (w_rd_addr == data_adr) && (w_rd_data == write_data);
    assign w_cnt_nxt = r_match_cnt + CNT_W'(1);
    assign w_all     = (w_cnt_nxt == CNT_W'(NUM_EXP));
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_fail_code <= FC_NONE;
            r_match_cnt <= '0;
            r_fail_addr <= '0;
            r_fail_data <= '0;
            r_cycle_cnt <= '0;
`ifdef MWC_UNORDERED_EN
            r_mask      <= '0;
`endif
        end else if (start) begin
            // Start wins over any bus write in the same cycle; that write is not evaluated.
            r_state     <= RUN;
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_fail_code <= FC_NONE;
            r_match_cnt <= '0;
            r_fail_addr <= '0;
            r_fail_data <= '0;
            r_cycle_cnt <= '0;
`ifdef MWC_UNORDERED_EN
            r_mask      <= '0;
`endif
        end else if (r_state == RUN) begin
            if (r_cycle_cnt != '1) begin
                r_cycle_cnt <= r_cycle_cnt + 32'd1;
            end
            if (w_check && !w_hit) begin
                r_state     <= FAIL;
                r_busy      <= 1'b0;
                r_done      <= 1'b1;
                r_fail_code <= FC_MISMATCH;
                r_fail_addr <= data_adr;
                r_fail_data <= write_data;
            end else if (w_check && w_all) begin
                r_state     <= PASS;
                r_busy      <= 1'b0;
                r_done      <= 1'b1;
                r_pass      <= 1'b1;
                r_match_cnt <= w_cnt_nxt;
`ifdef MWC_UNORDERED_EN
                r_mask      <= w_mask_nxt;
`endif
            end else begin
                if (w_check) begin
                    r_match_cnt <= w_cnt_nxt;
`ifdef MWC_UNORDERED_EN
                    r_mask      <= w_mask_nxt;
`endif
                end
                if (w_timeout) begin
                    r_state     <= FAIL;
                    r_busy      <= 1'b0;
                    r_done      <= 1'b1;
                    r_fail_code <= FC_TIMEOUT;
                end
            end
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign pass      = r_pass;
    assign fail_code = r_fail_code;
    assign match_cnt = r_match_cnt;
    assign fail_addr = r_fail_addr;
    assign fail_data = r_fail_data;
    assign cycle_cnt = r_cycle_cnt;

endmodule

// File: tb/tb_mem_write_checker.sv
// Scoreboard bench for mem_write_checker: dut1 has a single-entry table, dut2 two entries.
// Expected status words are queued with each stimulus and popped after the clock edge.
module tb_mem_write_checker;

    typedef struct packed {
        logic        busy;
        logic        done;
        logic        pass;
        logic [1:0]  fc;
        logic [2:0]  mcnt;
        logic [31:0] faddr;
        logic [31:0] fdata;
        logic [31:0] cyc;
    } stat_t;

    typedef struct {
        logic        strt;
        logic        mw;
        logic [31:0] adr;
        logic [31:0] dat;
        stat_t       e;
    } step_t;

    logic clk;
    logic rst_n;

    logic        s1_start, s1_we, s1_idx, s1_mw;
    logic [31:0] s1_ea, s1_ed, s1_adr, s1_wd;
    logic        o1_busy, o1_done, o1_pass;
    logic [1:0]  o1_fc;
    logic        o1_mcnt;
    logic [31:0] o1_faddr, o1_fdata, o1_cyc;

    logic        s2_start, s2_we, s2_idx, s2_mw;
    logic [31:0] s2_ea, s2_ed, s2_adr, s2_wd;
    logic        o2_busy, o2_done, o2_pass;
    logic [1:0]  o2_fc;
    logic [1:0]  o2_mcnt;
    logic [31:0] o2_faddr, o2_fdata, o2_cyc;

    stat_t sb_q[$];
    int n_total = 0;
    int n_bad   = 0;

    mem_write_checker #(
        .ADDR_W(32), .DATA_W(32), .NUM_EXP(1), .TIMEOUT_CYC(50), .IGNORE_ADDR(32'd96)
    ) dut1 (
        .clk(clk), .reset(rst_n), .start(s1_start),
        .exp_we(s1_we), .exp_idx(s1_idx), .exp_addr(s1_ea), .exp_data(s1_ed),
        .mem_write(s1_mw), .data_adr(s1_adr), .write_data(s1_wd),
        .busy(o1_busy), .done(o1_done), .pass(o1_pass), .fail_code(o1_fc),
        .match_cnt(o1_mcnt), .fail_addr(o1_faddr), .fail_data(o1_fdata), .cycle_cnt(o1_cyc)
    );

    mem_write_checker #(
        .ADDR_W(32), .DATA_W(32), .NUM_EXP(2), .TIMEOUT_CYC(50), .IGNORE_ADDR(32'd96)
    ) dut2 (
        .clk(clk), .reset(rst_n), .start(s2_start),
        .exp_we(s2_we), .exp_idx(s2_idx), .exp_addr(s2_ea), .exp_data(s2_ed),
        .mem_write(s2_mw), .data_adr(s2_adr), .write_data(s2_wd),
        .busy(o2_busy), .done(o2_done), .pass(o2_pass), .fail_code(o2_fc),
        .match_cnt(o2_mcnt), .fail_addr(o2_faddr), .fail_data(o2_fdata), .cycle_cnt(o2_cyc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", n_total, n_bad);
        $fatal(1, "watchdog");
    end

    function automatic stat_t st(input logic b, input logic d, input logic p, input logic [1:0] fc,
                                 input int mc, input int fa, input int fd, input int cy);
        stat_t s;
        s.busy = b; s.done = d; s.pass = p; s.fc = fc; s.mcnt = 3'(mc);
        s.faddr = 32'(fa); s.fdata = 32'(fd); s.cyc = 32'(cy);
        return s;
    endfunction

    function automatic stat_t obs(input int which);
        stat_t s;
        if (which == 1) begin
            s.busy = o1_busy; s.done = o1_done; s.pass = o1_pass; s.fc = o1_fc;
            s.mcnt = 3'(o1_mcnt); s.faddr = o1_faddr; s.fdata = o1_fdata; s.cyc = o1_cyc;
        end else begin
            s.busy = o2_busy; s.done = o2_done; s.pass = o2_pass; s.fc = o2_fc;
            s.mcnt = 3'(o2_mcnt); s.faddr = o2_faddr; s.fdata = o2_fdata; s.cyc = o2_cyc;
        end
        return s;
    endfunction

    function automatic step_t mk(input logic strt, input logic mw, input int adr, input int dat, input stat_t e);
        step_t s;
        s.strt = strt; s.mw = mw; s.adr = 32'(adr); s.dat = 32'(dat); s.e = e;
        return s;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        s1_start = 0; s1_we = 0; s1_idx = 0; s1_ea = 0; s1_ed = 0; s1_mw = 0; s1_adr = 0; s1_wd = 0;
        s2_start = 0; s2_we = 0; s2_idx = 0; s2_ea = 0; s2_ed = 0; s2_mw = 0; s2_adr = 0; s2_wd = 0;
    endtask

    task automatic drive(input int which, input logic strt, input logic mw, input logic [31:0] adr,
                         input logic [31:0] dat, input logic we, input logic [31:0] ea, input logic [31:0] ed);
        if (which == 1) begin
            s1_start = strt; s1_mw = mw; s1_adr = adr; s1_wd = dat; s1_we = we; s1_idx = 0; s1_ea = ea; s1_ed = ed;
        end else begin
            s2_start = strt; s2_mw = mw; s2_adr = adr; s2_wd = dat; s2_we = we; s2_idx = 0; s2_ea = ea; s2_ed = ed;
        end
        tick();
        clear_inputs();
    endtask

    task automatic load(input int which, input logic idx, input logic [31:0] a, input logic [31:0] d);
        if (which == 1) begin
            s1_we = 1; s1_idx = idx; s1_ea = a; s1_ed = d;
        end else begin
            s2_we = 1; s2_idx = idx; s2_ea = a; s2_ed = d;
        end
        tick();
        clear_inputs();
    endtask

    task automatic test_reset();
        stat_t g, e;
        rst_n = 1'b0;
        clear_inputs();
        #12;
        for (int w = 1; w <= 2; w++) begin
            sb_q.push_back(st(0, 0, 0, 2'd0, 0, 0, 0, 0));
            g = obs(w);
            e = sb_q.pop_front();
            n_total++;
            if (g !== e) begin
                n_bad++;
                $display("FAIL reset_state dut%0d: got=%h exp=%h", w, g, e);
            end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_in_order_pass();
        step_t tbl[5];
        stat_t g, e;
        load(1, 1'b0, 32'd100, 32'd25);
        tbl[0] = mk(1, 0, 0,   0,  st(1, 0, 0, 2'd0, 0, 0, 0, 0));
        tbl[1] = mk(0, 1, 96,  7,  st(1, 0, 0, 2'd0, 0, 0, 0, 1));
        tbl[2] = mk(0, 1, 100, 25, st(0, 1, 1, 2'd0, 1, 0, 0, 2));
        tbl[3] = mk(0, 0, 0,   0,  st(0, 1, 1, 2'd0, 1, 0, 0, 2));
        tbl[4] = mk(0, 1, 100, 9,  st(0, 1, 1, 2'd0, 1, 0, 0, 2));
        for (int i = 0; i < 5; i++) begin
            sb_q.push_back(tbl[i].e);
            drive(1, tbl[i].strt, tbl[i].mw, tbl[i].adr, tbl[i].dat, 0, 0, 0);
            g = obs(1);
            e = sb_q.pop_front();
            n_total++;
            if (g !== e) begin
                n_bad++;
                $display("FAIL pass_seq[%0d]: got=%h exp=%h", i, g, e);
            end
        end
    endtask

    task automatic test_mismatch();
        step_t tbl[4];
        stat_t g, e;
        tbl[0] = mk(1, 0, 0,   0,  st(1, 0, 0, 2'd0, 0, 0,   0,  0));
        tbl[1] = mk(0, 1, 100, 24, st(0, 1, 0, 2'd1, 0, 100, 24, 1));
        tbl[2] = mk(0, 1, 100, 25, st(0, 1, 0, 2'd1, 0, 100, 24, 1));
        tbl[3] = mk(0, 0, 0,   0,  st(0, 1, 0, 2'd1, 0, 100, 24, 1));
        for (int i = 0; i < 4; i++) begin
            sb_q.push_back(tbl[i].e);
            drive(1, tbl[i].strt, tbl[i].mw, tbl[i].adr, tbl[i].dat, 0, 0, 0);
            g = obs(1);
            e = sb_q.pop_front();
            n_total++;
            if (g !== e) begin
                n_bad++;
                $display("FAIL mismatch_seq[%0d]: got=%h exp=%h", i, g, e);
            end
        end
    endtask

    task automatic test_timeout();
        stat_t g, e;
        drive(1, 1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 49; i++) drive(1, 0, 0, 0, 0, 0, 0, 0);
        sb_q.push_back(st(1, 0, 0, 2'd0, 0, 0, 0, 49));
        sb_q.push_back(st(0, 1, 0, 2'd2, 0, 0, 0, 50));
        sb_q.push_back(st(0, 1, 0, 2'd2, 0, 0, 0, 50));
        for (int k = 0; k < 3; k++) begin
            g = obs(1);
            e = sb_q.pop_front();
            n_total++;
            if (g !== e) begin
                n_bad++;
                $display("FAIL timeout[%0d]: got=%h exp=%h", k, g, e);
            end
            drive(1, 0, 0, 0, 0, 0, 0, 0);
            if (k == 1) repeat (3) drive(1, 0, 0, 0, 0, 0, 0, 0);
        end
    endtask

    task automatic test_timeout_edge();
        stat_t g, e;
        logic [31:0] wdat [2];
        wdat[0] = 32'd25;
        wdat[1] = 32'd7;
        for (int k = 0; k < 2; k++) begin
            drive(1, 1, 0, 0, 0, 0, 0, 0);
            for (int i = 0; i < 49; i++) drive(1, 0, 0, 0, 0, 0, 0, 0);
            if (k == 0) sb_q.push_back(st(0, 1, 1, 2'd0, 1, 0, 0, 50));
            else        sb_q.push_back(st(0, 1, 0, 2'd1, 0, 100, 7, 50));
            drive(1, 0, 1, 32'd100, wdat[k], 0, 0, 0);
            g = obs(1);
            e = sb_q.pop_front();
            n_total++;
            if (g !== e) begin
                n_bad++;
                $display("FAIL timeout_edge[%0d]: got=%h exp=%h", k, g, e);
            end
        end
    endtask

    task automatic test_start_collide();
        step_t tbl[2];
        stat_t g, e;
        tbl[0] = mk(1, 1, 100, 24, st(1, 0, 0, 2'd0, 0, 0, 0, 0));
        tbl[1] = mk(0, 1, 100, 25, st(0, 1, 1, 2'd0, 1, 0, 0, 1));
        for (int i = 0; i < 2; i++) begin
            sb_q.push_back(tbl[i].e);
            drive(1, tbl[i].strt, tbl[i].mw, tbl[i].adr, tbl[i].dat, 0, 0, 0);
            g = obs(1);
            e = sb_q.pop_front();
            n_total++;
            if (g !== e) begin
                n_bad++;
                $display("FAIL start_collide[%0d]: got=%h exp=%h", i, g, e);
            end
        end
    endtask

    task automatic test_exp_we_run();
        stat_t g, e;
        drive(1, 1, 0, 0, 0, 0, 0, 0);
        sb_q.push_back(st(1, 0, 0, 2'd0, 0, 0, 0, 1));
        drive(1, 0, 0, 0, 0, 1, 32'd200, 32'd9);
        sb_q.push_back(st(0, 1, 1, 2'd0, 1, 0, 0, 2));
        for (int i = 0; i < 2; i++) begin
            if (i == 1) drive(1, 0, 1, 32'd100, 32'd25, 0, 0, 0);
            g = obs(1);
            e = sb_q.pop_front();
            n_total++;
            if (g !== e) begin
                n_bad++;
                $display("FAIL exp_we_run[%0d]: got=%h exp=%h", i, g, e);
            end
        end
    endtask

    task automatic test_back_to_back();
        step_t tbl[6];
        stat_t g, e;
        load(2, 1'b0, 32'd100, 32'd25);
        load(2, 1'b1, 32'd104, 32'd3);
        tbl[0] = mk(1, 0, 0,   0,  st(1, 0, 0, 2'd0, 0, 0, 0, 0));
        tbl[1] = mk(0, 1, 100, 25, st(1, 0, 0, 2'd0, 1, 0, 0, 1));
        for (int i = 0; i < 2; i++) begin
            sb_q.push_back(tbl[i].e);
            drive(2, tbl[i].strt, tbl[i].mw, tbl[i].adr, tbl[i].dat, 0, 0, 0);
            g = obs(2);
            e = sb_q.pop_front();
            n_total++;
            if (g !== e) begin
                n_bad++;
                $display("FAIL b2b_pre[%0d]: got=%h exp=%h", i, g, e);
            end
        end
        #2;
        rst_n = 1'b0;
        sb_q.push_back(st(0, 0, 0, 2'd0, 0, 0, 0, 0));
        #1;
        g = obs(2);
        e = sb_q.pop_front();
        n_total++;
        if (g !== e) begin
            n_bad++;
            $display("FAIL midrun_reset: got=%h exp=%h", g, e);
        end
        tick();
        rst_n = 1'b1;
        tbl[0] = mk(1, 0, 0,   0,  st(1, 0, 0, 2'd0, 0, 0, 0, 0));
        tbl[1] = mk(0, 1, 100, 25, st(1, 0, 0, 2'd0, 1, 0, 0, 1));
        tbl[2] = mk(0, 1, 104, 3,  st(0, 1, 1, 2'd0, 2, 0, 0, 2));
        tbl[3] = mk(1, 0, 0,   0,  st(1, 0, 0, 2'd0, 0, 0, 0, 0));
`ifdef MWC_UNORDERED_EN
        tbl[4] = mk(0, 1, 104, 3,  st(1, 0, 0, 2'd0, 1, 0, 0, 1));
        tbl[5] = mk(0, 1, 100, 25, st(0, 1, 1, 2'd0, 2, 0, 0, 2));
`else
        tbl[4] = mk(0, 1, 104, 3,  st(0, 1, 0, 2'd1, 0, 104, 3, 1));
        tbl[5] = mk(0, 1, 100, 25, st(0, 1, 0, 2'd1, 0, 104, 3, 1));
`endif
        for (int i = 0; i < 6; i++) begin
            sb_q.push_back(tbl[i].e);
            drive(2, tbl[i].strt, tbl[i].mw, tbl[i].adr, tbl[i].dat, 0, 0, 0);
            g = obs(2);
            e = sb_q.pop_front();
            n_total++;
            if (g !== e) begin
                n_bad++;
                $display("FAIL b2b_post[%0d]: got=%h exp=%h", i, g, e);
            end
        end
    endtask

    task automatic test_out_of_range_idx();
        stat_t g, e;
        #2;
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        load(1, 1'b1, 32'd5, 32'd5);
        sb_q.push_back(st(0, 0, 0, 2'd0, 0, 0, 0, 0));
        g = obs(1);
        e = sb_q.pop_front();
        n_total++;
        if (g !== e) begin
            n_bad++;
            $display("FAIL oor_idle: got=%h exp=%h", g, e);
        end
        drive(1, 1, 0, 0, 0, 0, 0, 0);
        sb_q.push_back(st(0, 1, 1, 2'd0, 1, 0, 0, 1));
        drive(1, 0, 1, 32'd100, 32'd25, 0, 0, 0);
        g = obs(1);
        e = sb_q.pop_front();
        n_total++;
        if (g !== e) begin
            n_bad++;
            $display("FAIL oor_pass: got=%h exp=%h", g, e);
        end
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_in_order_pass();
        test_mismatch();
        test_timeout();
        test_timeout_edge();
        test_start_collide();
        test_exp_we_run();
        test_back_to_back();
        test_out_of_range_idx();
        if (sb_q.size() != 0) begin
            n_total++;
            n_bad++;
            $display("FAIL scoreboard_drain: left=%0d required=0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
